alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_if.sv | 36 +++
 rtl/alu_sequencer.sv | 165 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Bundles the FIFO_IN, ALU and FIFO_OUT handshakes of the ALU sequencer.
// The master modport is the sequencer side; the slave modport is its environment.
interface alu_sequencer_if #(
  parameter int DATA_SIZE      = 16,
  parameter int OPERATION_SIZE = 2
);
  logic                                  enable;
  logic                                  empty_in;
  logic [OPERATION_SIZE+2*DATA_SIZE-1:0] fifo_in_data;
  logic                                  r_en_in;
  logic                                  alu_start;
  logic [OPERATION_SIZE-1:0]             alu_op;
  logic [DATA_SIZE-1:0]                  alu_a;
  logic [DATA_SIZE-1:0]                  alu_b;
  logic                                  alu_done;
  logic [DATA_SIZE-1:0]                  alu_result;
  logic                                  alu_ovf;
  logic                                  full_out;
  logic                                  w_en_out;
  logic [DATA_SIZE+3:0]                  fifo_out_data;
  logic                                  busy;
  logic [15:0]                           op_count;
  logic [7:0]                            err_count;

  modport master (
    input  enable, empty_in, fifo_in_data, alu_done, alu_result, alu_ovf, full_out,
    output r_en_in, alu_start, alu_op, alu_a, alu_b, w_en_out, fifo_out_data,
           busy, op_count, err_count
  );

  modport slave (
    output enable, empty_in, fifo_in_data, alu_done, alu_result, alu_ovf, full_out,
    input  r_en_in, alu_start, alu_op, alu_a, alu_b, w_en_out, fifo_out_data,
           busy, op_count, err_count
  );
endinterface

// File: rtl/alu_sequencer.sv
// Pops {op, data1, data0} from FIFO_IN, launches the external ALU, waits for its result
// with a timeout, and pushes {status, result} to FIFO_OUT while counting pushes and errors.
module alu_sequencer #(
  parameter int DATA_SIZE      = 16,
  parameter int OPERATION_SIZE = 2,
  parameter int TIMEOUT        = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_sequencer_if.master bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] EXEC  = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] PUSH  = 3'd4;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [OPERATION_SIZE-1:0] OP_ADD = OPERATION_SIZE'(1);
  localparam logic [OPERATION_SIZE-1:0] OP_SUB = OPERATION_SIZE'(2);

  localparam logic [3:0] ST_OP_ERR  = 4'b1001;
  localparam logic [3:0] ST_TIMEOUT = 4'b1010;

  logic [2:0]                state_r;
  logic [2:0]                state_nx_s;
  logic [CNT_W-1:0]          cnt_r;
  logic [OPERATION_SIZE-1:0] op_r;
  logic [DATA_SIZE-1:0]      a_r;
  logic [DATA_SIZE-1:0]      b_r;
  logic [DATA_SIZE+3:0]      out_r;
  logic [15:0]               op_count_r;
  logic [7:0]                err_count_r;
  logic                      alu_start_r;
  logic                      busy_r;
  logic                      r_en_s;
  logic                      w_en_s;
  logic [OPERATION_SIZE-1:0] fetch_op_s;
  logic [DATA_SIZE-1:0]      fetch_a_s;
  logic [DATA_SIZE-1:0]      fetch_b_s;
  logic                      fetch_ok_s;
  logic                      timeout_s;

  function automatic logic [DATA_SIZE+3:0] pack_out(input logic [3:0]           status,
                                                    input logic [DATA_SIZE-1:0] result);
    return {status, result};
  endfunction

  function automatic logic is_error(input logic [3:0] status);
    return (status[1:0] != 2'b00);
  endfunction

  assign fetch_op_s = bus.fifo_in_data[OPERATION_SIZE+2*DATA_SIZE-1 -: OPERATION_SIZE];
  assign fetch_b_s  = bus.fifo_in_data[2*DATA_SIZE-1 -: DATA_SIZE];
  assign fetch_a_s  = bus.fifo_in_data[DATA_SIZE-1:0];
  assign fetch_ok_s = (fetch_op_s == OP_ADD) || (fetch_op_s == OP_SUB);
  // WAIT has already lasted TIMEOUT cycles once this cycle ends without alu_done.
  assign timeout_s  = (cnt_r == CNT_W'(TIMEOUT - 1));

  // The pop strobe is gated by reset so nothing is consumed while rst_n is low.
  assign bus.r_en_in       = r_en_s & rst_n;
  assign bus.w_en_out      = w_en_s;
  assign bus.alu_start     = alu_start_r;
  assign bus.alu_op        = op_r;
  assign bus.alu_a         = a_r;
  assign bus.alu_b         = b_r;
  assign bus.fifo_out_data = out_r;
  assign bus.busy          = busy_r;
  assign bus.op_count      = op_count_r;
  assign bus.err_count     = err_count_r;

  // Next-state decode plus the combinational FIFO strobes.
  always_comb begin
    state_nx_s = state_r;
    r_en_s     = 1'b0;
    w_en_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.enable && !bus.empty_in) begin
          r_en_s     = 1'b1;
          state_nx_s = FETCH;
        end else begin
          state_nx_s = IDLE;
        end
      end
      FETCH: begin
        if (fetch_ok_s) begin
          state_nx_s = EXEC;
        end else begin
          state_nx_s = PUSH;
        end
      end
      EXEC: state_nx_s = WAIT;
      WAIT: begin
        if (bus.alu_done || timeout_s) begin
          state_nx_s = PUSH;
        end else begin
          state_nx_s = WAIT;
        end
      end
      PUSH: begin
        if (!bus.full_out) begin
          w_en_s     = 1'b1;
          state_nx_s = IDLE;
        end else begin
          state_nx_s = PUSH;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State, launch/busy flags, operand latches, result capture and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      op_r        <= '0;
      a_r         <= '0;
      b_r         <= '0;
      out_r       <= '0;
      op_count_r  <= 16'd0;
      err_count_r <= 8'd0;
      alu_start_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      alu_start_r <= (state_nx_s == EXEC);
      busy_r      <= (state_nx_s != IDLE);
      case (state_r)
        FETCH: begin
          op_r <= fetch_op_s;
          a_r  <= fetch_a_s;
          b_r  <= fetch_b_s;
          if (!fetch_ok_s) begin
            out_r <= pack_out(ST_OP_ERR, '0);
          end
        end
        EXEC: cnt_r <= '0;
        WAIT: begin
          if (bus.alu_done) begin
            out_r <= pack_out({1'b1, bus.alu_ovf, 2'b00}, bus.alu_result);
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
            if (timeout_s) begin
              out_r <= pack_out(ST_TIMEOUT, '0);
            end
          end
        end
        PUSH: begin
          if (w_en_s) begin
            op_count_r <= op_count_r + 16'd1;
            if (is_error(out_r[DATA_SIZE+3:DATA_SIZE]) && (err_count_r != 8'hFF)) begin
              err_count_r <= err_count_r + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomised scoreboard bench for alu_sequencer: the bench plays FIFO_IN, the ALU and
// FIFO_OUT, predicts every pushed word from the operation rules and checks it in order.
module tb_alu_sequencer;

  localparam int DW = 16;
  localparam int OW = 2;
  localparam int TO = 15;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    int          d;
    logic [15:0] res;
    logic        ovf;
  } op_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_sequencer_if #(.DATA_SIZE(DW), .OPERATION_SIZE(OW)) bus ();

  alu_sequencer #(.DATA_SIZE(DW), .OPERATION_SIZE(OW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [33:0] fifo_q[$];
  op_t         launch_q[$];
  logic [19:0] exp_q[$];

  int          checks   = 0;
  int          errors   = 0;
  logic [15:0] m_ops    = 16'd0;
  logic [7:0]  m_errs   = 8'd0;
  bit          cnt_chk  = 1'b0;
  bit          pop_pending = 1'b0;
  bit          prev_start  = 1'b0;
  int          bp_mode  = 0;
  int          cyc      = 0;
  int          r_cyc    = 0;
  int          w_cyc    = 0;
  int          n_pops   = 0;
  int          n_pushes = 0;
  int          n_starts = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event occurred, expected none", name);
  endtask

  // Reference rules: add/sub set ovf on carry/borrow, other opcodes are errors,
  // and a result arriving later than TIMEOUT cycles after launch becomes a timeout.
  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input int d);
    op_t         t;
    logic [16:0] wide;
    logic [19:0] e;
    wide = (op == 2'b01) ? ({1'b0, a} + {1'b0, b}) : ({1'b0, a} - {1'b0, b});
    t.op = op; t.a = a; t.b = b; t.d = d;
    t.res = wide[15:0];
    t.ovf = wide[16];
    if (op != 2'b01 && op != 2'b10) begin
      e = 20'h90000;
    end else begin
      launch_q.push_back(t);
      if (d > TO) e = 20'hA0000;
      else        e = {1'b1, t.ovf, 2'b00, t.res};
    end
    fifo_q.push_back({op, b, a});
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || fifo_q.size() != 0 || bus.busy) && n < budget);
    if (exp_q.size() != 0 || fifo_q.size() != 0 || bus.busy) flag("wait_idle_budget");
  endtask

  task automatic wait_start(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.alu_start && n < budget);
    if (!bus.alu_start) flag("wait_start_budget");
  endtask

  // Environment driver: FIFO_IN read port, ALU responder and FIFO_OUT backpressure.
  initial begin
    op_t cur;
    int  cnt;
    logic [15:0] rres;
    logic        rovf;
    cnt = 0; rres = 16'd0; rovf = 1'b0;
    bus.empty_in = 1'b1; bus.fifo_in_data = 34'd0;
    bus.alu_done = 1'b0; bus.alu_result = 16'd0; bus.alu_ovf = 1'b0;
    bus.full_out = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (pop_pending && fifo_q.size() != 0) bus.fifo_in_data = fifo_q.pop_front();
      bus.empty_in = (fifo_q.size() == 0);
      bus.alu_done = 1'b0;
      if (!rst_n) begin
        cnt = 0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.alu_done = 1'b1; bus.alu_result = rres; bus.alu_ovf = rovf;
        end
      end
      if (rst_n && bus.alu_start) begin
        if (launch_q.size() == 0) begin
          flag("unexpected_alu_start");
        end else begin
          cur = launch_q.pop_front();
          chk("launch_alu_op", 32'(bus.alu_op), 32'(cur.op));
          chk("launch_alu_a", 32'(bus.alu_a), 32'(cur.a));
          chk("launch_alu_b", 32'(bus.alu_b), 32'(cur.b));
          cnt = cur.d;
          rres = (cur.d > TO) ? 16'hDEAD : cur.res;
          rovf = (cur.d > TO) ? 1'b1 : cur.ovf;
        end
      end
      case (bp_mode)
        0:       bus.full_out = 1'b0;
        1:       bus.full_out = ($urandom_range(0, 3) == 0);
        default: ;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every push and tracks the expected counters.
  initial begin
    logic [19:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      pop_pending = bus.r_en_in;
      if (rst_n) begin
        if (bus.r_en_in && bus.w_en_out) flag("r_en_and_w_en_same_cycle");
        if (cnt_chk) begin
          chk("op_count", 32'(bus.op_count), 32'(m_ops));
          chk("err_count", 32'(bus.err_count), 32'(m_errs));
          cnt_chk = 1'b0;
        end
        if (bus.alu_start) begin
          n_starts++;
          if (prev_start) flag("alu_start_longer_than_one_cycle");
        end
        if (bus.r_en_in) begin
          n_pops++;
          r_cyc = cyc;
        end
        if (bus.w_en_out) begin
          n_pushes++;
          w_cyc = cyc;
          if (exp_q.size() == 0) begin
            flag("unexpected_push");
          end else begin
            e = exp_q.pop_front();
            chk("fifo_out_data", 32'(bus.fifo_out_data), 32'(e));
            m_ops = m_ops + 16'd1;
            if (e[17:16] != 2'b00 && m_errs != 8'hFF) m_errs = m_errs + 8'd1;
            cnt_chk = 1'b1;
          end
        end
      end
      prev_start = bus.alu_start;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    int np0;
    int s0;
    int n;
    bus.enable = 1'b1;
    // Work is pending and enabled while reset is held: nothing may move.
    issue(2'b01, 16'h0005, 16'h0003, 1);
    repeat (3) @(negedge clk);
    chk("rst_r_en_in", 32'(bus.r_en_in), 32'd0);
    chk("rst_alu_start", 32'(bus.alu_start), 32'd0);
    chk("rst_w_en_out", 32'(bus.w_en_out), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
    chk("rst_alu_a", 32'(bus.alu_a), 32'd0);
    chk("rst_alu_b", 32'(bus.alu_b), 32'd0);
    chk("rst_fifo_out_data", 32'(bus.fifo_out_data), 32'd0);
    chk("rst_op_count", 32'(bus.op_count), 32'd0);
    chk("rst_err_count", 32'(bus.err_count), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_idle(50);
    @(negedge clk);
    chk("add_latency_r_en_to_w_en", 32'(w_cyc - r_cyc), 32'd4);
    chk("add_op_count", 32'(bus.op_count), 32'd1);

    // Illegal opcode: no ALU launch, error status pushed.
    s0 = n_starts;
    issue(2'b11, 16'hABCD, 16'h1234, 1);
    wait_idle(50);
    @(negedge clk);
    chk("badop_no_alu_start", 32'(n_starts), 32'(s0));
    chk("badop_err_count", 32'(bus.err_count), 32'd1);

    // Timeout with a late alu_done, then a result on the very last WAIT cycle.
    issue(2'b10, 16'd100, 16'd7, 16);
    issue(2'b10, 16'd7, 16'd100, 15);
    wait_idle(100);
    @(negedge clk);
    chk("timeout_err_count", 32'(bus.err_count), 32'd2);
    chk("timeout_op_count", 32'(bus.op_count), 32'd4);

    // FIFO_OUT full for five PUSH cycles with another op waiting in FIFO_IN.
    issue(2'b01, 16'h1234, 16'h0101, 1);
    issue(2'b01, 16'h0001, 16'h0002, 2);
    wait_start(50);
    bp_mode = 3;
    bus.full_out = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_w_en_low", 32'(bus.w_en_out), 32'd0);
      chk("stall_no_r_en", 32'(bus.r_en_in), 32'd0);
      chk("stall_data_stable", 32'(bus.fifo_out_data), 32'h81335);
    end
    @(posedge clk); #1 bus.full_out = 1'b0;
    @(negedge clk);
    chk("stall_push_on_6th", 32'(bus.w_en_out), 32'd1);
    bp_mode = 0;
    wait_idle(60);

    // Three queued ops; enable drops during the second one.
    @(posedge clk); #1 bus.enable = 1'b0;
    for (int k = 0; k < 3; k++)
      issue(2'b01 + 2'(k % 2), 16'($urandom), 16'($urandom), $urandom_range(1, 3));
    p0 = n_pops;
    @(posedge clk); #1 bus.enable = 1'b1;
    n = 0;
    while (n_pops < p0 + 2 && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1 bus.enable = 1'b0;
    n = 0;
    while ((exp_q.size() > 1 || bus.busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    chk("disable_second_completes", 32'(exp_q.size()), 32'd1);
    chk("disable_third_not_popped", 32'(n_pops), 32'(p0 + 2));
    chk("disable_stays_idle", 32'(bus.busy), 32'd0);
    @(posedge clk); #1 bus.enable = 1'b1;
    wait_idle(60);
    chk("reenable_third_popped", 32'(n_pops), 32'(p0 + 3));

    // Asynchronous reset in the middle of WAIT.
    issue(2'b01, 16'h00FF, 16'h0001, 10);
    wait_start(50);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    chk("async_rst_alu_a", 32'(bus.alu_a), 32'd0);
    chk("async_rst_alu_b", 32'(bus.alu_b), 32'd0);
    chk("async_rst_fifo_out_data", 32'(bus.fifo_out_data), 32'd0);
    chk("async_rst_op_count", 32'(bus.op_count), 32'd0);
    chk("async_rst_err_count", 32'(bus.err_count), 32'd0);
    chk("async_rst_w_en_out", 32'(bus.w_en_out), 32'd0);
    exp_q.delete();
    launch_q.delete();
    fifo_q.delete();
    m_ops = 16'd0;
    m_errs = 8'd0;
    cnt_chk = 1'b0;
    np0 = n_pushes;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("no_push_after_reset", 32'(n_pushes), 32'(np0));
    chk("idle_after_reset", 32'(bus.busy), 32'd0);
    issue(2'b10, 16'h0010, 16'h0001, 2);
    wait_idle(50);
    @(negedge clk);
    chk("post_reset_op_count", 32'(bus.op_count), 32'd1);

    // Randomised traffic with backpressure and enable toggling.
    bp_mode = 1;
    for (int i = 0; i < 120; i++) begin
      int r;
      int d;
      r = $urandom_range(0, 9);
      if (r < 7)       d = $urandom_range(1, 4);
      else if (r == 7) d = TO;
      else             d = $urandom_range(TO + 1, TO + 3);
      issue(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), d);
      @(posedge clk); #1 bus.enable = ($urandom_range(0, 4) != 0);
      repeat ($urandom_range(0, 8)) @(posedge clk);
    end
    @(posedge clk); #1 bus.enable = 1'b1;
    wait_idle(8000);
    repeat (2) @(negedge clk);
    chk("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("final_op_count", 32'(bus.op_count), 32'(m_ops));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
